led_pattern_ctrl: RTL and testbench
===================================

LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 SHALL have parameter TICK_CNT, default 5000, giving the pattern step period as TICK_CNT+1 sys_clk cycles.
REQ-002 SHALL have parameter DEB_CNT, default 1000, giving the key stable-time in sys_clk cycles required to accept a level change.
REQ-003 SHALL have port sys_clk, input, 1 bit: system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port key_mode, input, 1 bit: asynchronous push-button, active-low; a press advances the mode.
REQ-006 SHALL have port key_run, input, 1 bit: asynchronous push-button, active-low; a press toggles between run and pause.
REQ-007 SHALL have port led, output reg, 4 bits: LED drive, 1 = on.
REQ-008 SHALL have port mode, output, 2 bits: current pattern mode.
REQ-009 SHALL have port running, output, 1 bit: high in RUN, low in PAUSE.

Function
REQ-010 SHALL pass each key through a 2-FF synchronizer, then a debouncer that accepts a new level only after DEB_CNT consecutive cycles at that level.
REQ-011 SHALL generate a single-cycle press pulse on each accepted 1->0 transition of a debounced key; a held key produces exactly one pulse.
REQ-012 SHALL run a tick counter 0..TICK_CNT inclusive, asserting tick when it equals TICK_CNT and wrapping to 0 on the next cycle.
REQ-013 SHALL advance the tick counter only in RUN; in PAUSE it holds its value and tick is never asserted.
REQ-014 SHALL implement a two-state FSM, RUN and PAUSE; a key_run press toggles the state on the following edge.
REQ-015 SHALL update led only on a cycle where tick is asserted, with led taking the new value at that same edge.
REQ-016 SHALL implement mode 0, FLOW_L: led <= {led[2:0], led[3]}.
REQ-017 SHALL implement mode 1, FLOW_R: led <= {led[0], led[3:1]}.
REQ-018 SHALL implement mode 2, BLINK: led <= ~led.
REQ-019 SHALL implement mode 3, BOUNCE: led follows 0001,0010,0100,1000,0100,0010,0001,... using an internal dir bit; dir flips when led is at 1000 or 0001.
REQ-020 SHALL, on a key_mode press, advance mode modulo 4 (3 wraps to 0) in both RUN and PAUSE.
REQ-021 SHALL, on the same edge as a mode change, load led with the new mode's seed, clear the tick counter, and set dir to up.
REQ-022 SHALL use seed 1111 for BLINK and seed 0001 for all other modes.
REQ-023 SHALL keep the FSM state unchanged on a mode change; a mode change in PAUSE leaves the block paused with the seed displayed.
REQ-024 SHALL apply both actions on the same edge when a key_mode press and a key_run press occur in the same cycle.
REQ-025 SHALL give a key_mode press priority over a tick occurring in the same cycle, so the seed is loaded and no shift is applied.

Reset
REQ-026 SHALL, during reset, hold led=0001, mode=0, state RUN (running=1), tick counter 0, dir up, both debounced key levels 1 (released), and both debounce counters 0.
REQ-027 SHALL, when a key is held low through reset deassertion, produce one press pulse DEB_CNT cycles after the synchronizer output goes low.
REQ-028 SHALL, on reset asserted mid-pattern, return all state to its reset values asynchronously, with no residual press pulse after release.

Structure
REQ-029 SHALL define the mode encodings (FLOW_L=0, FLOW_R=1, BLINK=2, BOUNCE=3), the seeds, and the default TICK_CNT and DEB_CNT in a shared package led_pkg.
REQ-030 SHALL implement the synchronizer, debouncer, and press-pulse logic as sub-module key_debounce (parameter DEB_CNT; outputs key_level and key_press), instantiated twice.
REQ-031 SHALL keep the FSM, tick counter, and pattern datapath in led_pattern_ctrl.

Verification (bench parameters TICK_CNT=5, DEB_CNT=4)
REQ-032 SHALL check: reset released, no keys -> led 0001,0010,0100,1000,0001 with exactly 6 clocks between changes.
REQ-033 SHALL check: key_mode pulsed low for 2 cycles (a glitch) -> no mode change; held low for 20 cycles -> mode=1 once, led=0001, then rotates right (1000 next).
REQ-034 SHALL check: three accepted key_mode presses from reset -> mode=3, led sequence 0001,0010,0100,1000,0100,0010,0001; a fourth press -> mode=0.
REQ-035 SHALL check: key_run press while in FLOW_L at led=0100 -> running=0, led frozen for 100 cycles; a second press -> resumes, next step 1000 after the remaining counter cycles.
REQ-036 SHALL check: key_mode and key_run presses aligned to the same cycle in RUN, mode 1 -> mode=2, led=1111, running=0, led static thereafter.
REQ-037 SHALL check: sys_rst_n asserted mid-BOUNCE with dir down -> led=0001, mode=0, running=1 immediately; after release the first step is 0010.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern controller: mode encodings, run states,
// pattern seeds and default timing parameters.
package led_pkg;

  typedef enum logic [1:0] {
    FLOW_L = 2'd0,
    FLOW_R = 2'd1,
    BLINK  = 2'd2,
    BOUNCE = 2'd3
  } mode_e;

  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } run_state_e;

  localparam int TICK_CNT_DEFAULT = 5000;
  localparam int DEB_CNT_DEFAULT  = 1000;

  localparam logic [3:0] SEED_BLINK = 4'b1111;
  localparam logic [3:0] SEED_OTHER = 4'b0001;

  function automatic logic [3:0] mode_seed(input mode_e m);
    return (m == BLINK) ? SEED_BLINK : SEED_OTHER;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioning: 2-FF synchronizer, stable-time debouncer and a
// single-cycle pulse on each accepted press (high-to-low level change).
module key_debounce
  import led_pkg::*;
#(
  parameter int DEB_CNT = DEB_CNT_DEFAULT
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press
);

  localparam int CW = (DEB_CNT > 0) ? $clog2(DEB_CNT + 1) : 1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // Any cycle where the synchronized input agrees with the accepted level
  // restarts the stable-time count.
  always_comb begin
    sync1_d = key_in;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CNT - 1)) begin
        level_d = sync2_q;
        press_d = level_q & ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign key_level = level_q;
  assign key_press = press_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Four-LED pattern generator with debounced mode/run keys, a run/pause FSM,
// a step-rate tick counter and the pattern datapath.
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int TICK_CNT = TICK_CNT_DEFAULT,
  parameter int DEB_CNT  = DEB_CNT_DEFAULT
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_mode,
  input  logic       key_run,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic       running
);

  localparam int TW = (TICK_CNT > 0) ? $clog2(TICK_CNT + 1) : 1;

  logic          mode_press, run_press;
  run_state_e    state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [3:0]    led_q, led_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          dir_up_q, dir_up_d;
  logic          tick;
  logic          bounce_up;

  key_debounce #(.DEB_CNT(DEB_CNT)) u_key_mode (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key_mode),
    .key_level (),
    .key_press (mode_press)
  );

  key_debounce #(.DEB_CNT(DEB_CNT)) u_key_run (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key_run),
    .key_level (),
    .key_press (run_press)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= RUN;
      mode_q   <= FLOW_L;
      led_q    <= SEED_OTHER;
      cnt_q    <= '0;
      dir_up_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      led_q    <= led_d;
      cnt_q    <= cnt_d;
      dir_up_q <= dir_up_d;
    end
  end

  always_comb begin
    tick      = (state_q == RUN) && (cnt_q == TW'(TICK_CNT));
    state_d   = state_q;
    mode_d    = mode_q;
    led_d     = led_q;
    cnt_d     = cnt_q;
    dir_up_d  = dir_up_q;
    bounce_up = dir_up_q;

    if (run_press) begin
      state_d = (state_q == RUN) ? PAUSE : RUN;
    end

    if (state_q == RUN) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // A mode change restarts the pattern and wins over a coincident tick.
    if (mode_press) begin
      mode_d   = mode_e'(mode_q + 2'd1);
      led_d    = mode_seed(mode_d);
      cnt_d    = '0;
      dir_up_d = 1'b1;
    end else if (tick) begin
      case (mode_q)
        FLOW_L: led_d = {led_q[2:0], led_q[3]};
        FLOW_R: led_d = {led_q[0], led_q[3:1]};
        BLINK:  led_d = ~led_q;
        BOUNCE: begin
          if (led_q == 4'b1000) begin
            bounce_up = 1'b0;
          end else if (led_q == 4'b0001) begin
            bounce_up = 1'b1;
          end
          led_d    = bounce_up ? {led_q[2:0], 1'b0} : {1'b0, led_q[3:1]};
          dir_up_d = bounce_up;
        end
      endcase
    end
  end

  assign led     = led_q;
  assign mode    = mode_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl (TICK_CNT=5, DEB_CNT=4): a timed vector
// table for the free-running and mode-key paths, then hand-written sequences.
module tb_led_pattern_ctrl;

  localparam int TICK_CNT = 5;
  localparam int DEB_CNT  = 4;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       key_mode  = 1'b1;
  logic       key_run   = 1'b1;
  logic [3:0] led;
  logic [1:0] mode;
  logic       running;

  int n_checks = 0;
  int n_errors = 0;

  always #5 sys_clk = ~sys_clk;

  led_pattern_ctrl #(
    .TICK_CNT (TICK_CNT),
    .DEB_CNT  (DEB_CNT)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_mode  (key_mode),
    .key_run   (key_run),
    .led       (led),
    .mode      (mode),
    .running   (running)
  );

  typedef struct {
    logic       km;
    logic       kr;
    int         cycles;
    logic [3:0] led;
    logic [1:0] mode;
    logic       running;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    key_mode  = 1'b1;
    key_run   = 1'b1;
    idle(3);
    sys_rst_n = 1'b1;
  endtask

  // Holds the selected keys low until just after the edge where the press
  // takes effect (2 sync + DEB_CNT debounce + 1 action edge), then releases.
  task automatic press_hold(input logic m, input logic r);
    if (m) key_mode = 1'b0;
    if (r) key_run = 1'b0;
    idle(2 + DEB_CNT + 1);
    key_mode = 1'b1;
    key_run  = 1'b1;
  endtask

  task automatic check_change(input string name, input int exp_led, input int exp_cyc);
    logic [3:0] prev;
    int cyc;
    prev = led;
    cyc  = 0;
    do begin
      @(negedge sys_clk);
      cyc++;
    end while (led == prev && cyc < 200);
    check({name, "_led"}, led, exp_led);
    check({name, "_cycles"}, cyc, exp_cyc);
    $display("step %s: led=%b after %0d cycles", name, led, cyc);
  endtask

  task automatic count_changes(input int n, output int changes);
    logic [3:0] prev;
    changes = 0;
    prev = led;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      if (led != prev) changes++;
      prev = led;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int changes;

    // Cumulative timeline from reset release; led steps every 6 edges.
    vecs[0]  = '{1'b1, 1'b1, 5,  4'b0001, 2'd0, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 1,  4'b0010, 2'd0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 5,  4'b0010, 2'd0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1,  4'b0100, 2'd0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 6,  4'b1000, 2'd0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 6,  4'b0001, 2'd0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 2,  4'b0001, 2'd0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 4,  4'b0010, 2'd0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 6,  4'b0100, 2'd0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 6,  4'b1000, 2'd0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1,  4'b0001, 2'd1, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 6,  4'b1000, 2'd1, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 7,  4'b0100, 2'd1, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 10, 4'b0010, 2'd1, 1'b1};

    idle(3);
    check("reset_led", led, 4'b0001);
    check("reset_mode", mode, 0);
    check("reset_running", running, 1);
    sys_rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      key_mode = vecs[i].km;
      key_run  = vecs[i].kr;
      idle(vecs[i].cycles);
      check($sformatf("vec%0d_led", i), led, vecs[i].led);
      check($sformatf("vec%0d_mode", i), mode, vecs[i].mode);
      check($sformatf("vec%0d_running", i), running, vecs[i].running);
      $display("vec %0d: led=%b mode=%0d running=%0b", i, led, mode, running);
    end

    // Mode sequence through all four patterns.
    do_reset();
    press_hold(1'b1, 1'b0);
    check("m1_mode", mode, 1);
    check("m1_led", led, 4'b0001);
    idle(8);
    press_hold(1'b1, 1'b0);
    check("m2_mode", mode, 2);
    check("m2_led", led, 4'b1111);
    check_change("blink0", 4'b0000, 6);
    check_change("blink1", 4'b1111, 6);
    idle(2);
    press_hold(1'b1, 1'b0);
    check("m3_mode", mode, 3);
    check("m3_led", led, 4'b0001);
    check_change("bounce1", 4'b0010, 6);
    check_change("bounce2", 4'b0100, 6);
    check_change("bounce3", 4'b1000, 6);
    check_change("bounce4", 4'b0100, 6);
    check_change("bounce5", 4'b0010, 6);
    check_change("bounce6", 4'b0001, 6);
    press_hold(1'b1, 1'b0);
    check("m0_mode", mode, 0);
    check("m0_led", led, 4'b0001);
    $display("seq modes: mode=%0d led=%b", mode, led);

    // Mode press landing on the same edge as a tick: seed wins, counter restarts.
    do_reset();
    idle(5);
    press_hold(1'b1, 1'b0);
    check("prio_mode", mode, 1);
    check("prio_led", led, 4'b0001);
    check_change("prio_next", 4'b1000, 6);

    // Pause at 0100 with the counter at 4, then resume.
    do_reset();
    idle(9);
    press_hold(1'b0, 1'b1);
    check("pause_running", running, 0);
    check("pause_led", led, 4'b0100);
    count_changes(100, changes);
    check("pause_frozen_changes", changes, 0);
    check("pause_still_paused", running, 0);
    press_hold(1'b0, 1'b1);
    check("resume_running", running, 1);
    check("resume_led", led, 4'b0100);
    check_change("resume_step", 4'b1000, 2);

    // Simultaneous mode and run presses from RUN in FLOW_R.
    do_reset();
    press_hold(1'b1, 1'b0);
    idle(8);
    press_hold(1'b1, 1'b1);
    check("both_mode", mode, 2);
    check("both_led", led, 4'b1111);
    check("both_running", running, 0);
    count_changes(50, changes);
    check("both_static_changes", changes, 0);
    check("both_mode_held", mode, 2);
    $display("seq both: mode=%0d led=%b running=%0b", mode, led, running);

    // Asynchronous reset mid-BOUNCE while travelling down.
    do_reset();
    for (int p = 0; p < 3; p++) begin
      press_hold(1'b1, 1'b0);
      idle(8);
    end
    check("rb_mode", mode, 3);
    do begin
      @(negedge sys_clk);
    end while (led != 4'b1000 && !(n_checks < 0));
    check_change("rb_down", 4'b0100, 6);
    idle(2);
    sys_rst_n = 1'b0;
    #1;
    check("rb_async_led", led, 4'b0001);
    check("rb_async_mode", mode, 0);
    check("rb_async_running", running, 1);
    idle(3);
    sys_rst_n = 1'b1;
    check_change("rb_first_step", 4'b0010, 6);

    // A press still being debounced when reset hits must not survive it.
    key_mode = 1'b0;
    idle(4);
    sys_rst_n = 1'b0;
    idle(1);
    key_mode = 1'b1;
    idle(2);
    sys_rst_n = 1'b1;
    idle(20);
    check("residual_mode", mode, 0);

    // Key held low through reset release: one press DEB_CNT after sync.
    sys_rst_n = 1'b0;
    key_mode  = 1'b0;
    idle(3);
    sys_rst_n = 1'b1;
    idle(6);
    check("held_before", mode, 0);
    idle(1);
    check("held_press", mode, 1);
    idle(20);
    check("held_once", mode, 1);
    key_mode = 1'b1;
    idle(10);
    $display("seq reset: mode=%0d led=%b", mode, led);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
